calc_arbiter: RTL and testbench

- Shares one profile_gen calculation engine among N_CH acc_step_gen axis channels.
- Collects per-channel start_calc pulses and issues them to the engine one at a time, in round-robin order.
- Routes the engine's completion back to the requesting channel as that channel's acc_calc_done pulse.
- Tracks overrun, timeout and spurious-completion errors for the buf_exec status path.

---
 rtl/calc_arb_pkg.sv | 28 ++
 rtl/calc_arbiter_rr_pick.sv | 46 ++++
 rtl/calc_arbiter.sv | 146 ++++++++++++++
 tb/tb_calc_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_arb_pkg.sv
// Shared types, defaults and helpers for the profile_gen calculation arbiter.
package calc_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_GRANT     = 2'd1,
        S_WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int DEF_N_CH           = 32'sd8;
    localparam int DEF_CH_W           = 32'sd3;
    localparam int DEF_TIMEOUT_CYCLES = 32'sd1000;

    // Smallest r with 2**r >= value.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/calc_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at N_CH-1 -> 0.
module rr_pick
    import calc_arb_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int CH_W = DEF_CH_W
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] winner,
    output logic            any_req
);

    logic [2*N_CH-1:0] dbl_s;
    logic [N_CH-1:0]   rot_s;
    logic [CH_W-1:0]   off_s;
    logic [CH_W:0]     sum_s;

    // Rotating a doubled copy puts req[ptr] at bit 0.
    assign dbl_s   = {req, req} >> ptr;
    assign rot_s   = dbl_s[N_CH-1:0];
    assign any_req = |req;

    // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
    always_comb begin
        off_s = {CH_W{1'b0}};
        for (int i = N_CH - 32'sd1; i >= 32'sd0; i--) begin
            if (rot_s[i]) begin
                off_s = CH_W'(i);
            end else begin
                off_s = off_s;
            end
        end
    end

    // Rotate the index back, modulo N_CH.
    always_comb begin
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= (CH_W + 1)'(N_CH)) begin
            winner = CH_W'(sum_s - (CH_W + 1)'(N_CH));
        end else begin
            winner = sum_s[CH_W-1:0];
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one profile_gen engine among N_CH acc_step_gen channels in round-robin order,
// routing completions back and tracking overrun, timeout and spurious-done errors.
module calc_arbiter
    import calc_arb_pkg::*;
#(
    parameter int N_CH           = DEF_N_CH,
    parameter int CH_W           = DEF_CH_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] start_calc,
    output logic [N_CH-1:0] acc_calc_done,
    output logic            calc_start,
    output logic [CH_W-1:0] calc_sel,
    input  logic            calc_done,
    input  logic            clear_errors,
    output logic [N_CH-1:0] pending,
    output logic            busy,
    output logic            error_overrun,
    output logic            error_calc_timeout,
    output logic            error_spurious_done
);

    localparam int              CNT_W    = (clog2(TIMEOUT_CYCLES) > 32'sd0) ? clog2(TIMEOUT_CYCLES) : 32'sd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'sd1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 32'sd1);
    localparam logic [N_CH-1:0]  CH_ONE   = N_CH'(1'b1);

    if (clog2(N_CH) > CH_W) begin : g_ch_w_check
        $error("calc_arbiter: CH_W too narrow for N_CH");
    end

    arb_state_e      state_r, state_s;
    logic [N_CH-1:0] pending_r, pending_s, eff_s, grant_clear_s;
    logic [CH_W-1:0] rr_ptr_r, rr_ptr_s, calc_sel_r, calc_sel_s, winner_s, ptr_after_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic            calc_start_r, calc_start_s, busy_r, busy_s, any_req_s;
    logic [N_CH-1:0] acc_calc_done_r, acc_calc_done_s;
    logic            err_overrun_r, err_overrun_s, err_timeout_r, err_timeout_s;
    logic            err_spurious_r, err_spurious_s, timeout_ev_s;

    assign eff_s = pending_r | start_calc;

    rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_rr_pick (
        .req     (eff_s),
        .ptr     (rr_ptr_r),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    assign ptr_after_s = (calc_sel_r == LAST_CH) ? {CH_W{1'b0}} : calc_sel_r + CH_W'(1'b1);

    // Next-state, grant and completion decode.
    always_comb begin
        state_s         = state_r;
        rr_ptr_s        = rr_ptr_r;
        calc_sel_s      = calc_sel_r;
        wait_cnt_s      = wait_cnt_r;
        calc_start_s    = 1'b0;
        acc_calc_done_s = {N_CH{1'b0}};
        grant_clear_s   = {N_CH{1'b0}};
        timeout_ev_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (any_req_s) begin
                    calc_sel_s    = winner_s;
                    grant_clear_s = CH_ONE << winner_s;
                    state_s       = S_GRANT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_GRANT: begin
                calc_start_s = 1'b1;
                wait_cnt_s   = {CNT_W{1'b0}};
                state_s      = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Completion takes priority over a timeout landing in the same cycle.
                if (calc_done) begin
                    acc_calc_done_s = CH_ONE << calc_sel_r;
                    rr_ptr_s        = ptr_after_s;
                    state_s         = S_IDLE;
                end else if (wait_cnt_r == CNT_LAST) begin
                    timeout_ev_s = 1'b1;
                    rr_ptr_s     = ptr_after_s;
                    state_s      = S_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1'b1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Request queue, busy and sticky error flags; a new event beats clear_errors.
    always_comb begin
        pending_s      = (pending_r | start_calc) & ~grant_clear_s;
        busy_s         = (state_s != S_IDLE);
        err_overrun_s  = (err_overrun_r & ~clear_errors) | (|(start_calc & pending_r));
        err_timeout_s  = (err_timeout_r & ~clear_errors) | timeout_ev_s;
        err_spurious_s = (err_spurious_r & ~clear_errors) | (calc_done & (state_r != S_WAIT_DONE));
    end

    // State and output registers; reset drops queued requests and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= S_IDLE;
            pending_r       <= {N_CH{1'b0}};
            rr_ptr_r        <= {CH_W{1'b0}};
            calc_sel_r      <= {CH_W{1'b0}};
            wait_cnt_r      <= {CNT_W{1'b0}};
            calc_start_r    <= 1'b0;
            acc_calc_done_r <= {N_CH{1'b0}};
            busy_r          <= 1'b0;
            err_overrun_r   <= 1'b0;
            err_timeout_r   <= 1'b0;
            err_spurious_r  <= 1'b0;
        end else begin
            state_r         <= state_s;
            pending_r       <= pending_s;
            rr_ptr_r        <= rr_ptr_s;
            calc_sel_r      <= calc_sel_s;
            wait_cnt_r      <= wait_cnt_s;
            calc_start_r    <= calc_start_s;
            acc_calc_done_r <= acc_calc_done_s;
            busy_r          <= busy_s;
            err_overrun_r   <= err_overrun_s;
            err_timeout_r   <= err_timeout_s;
            err_spurious_r  <= err_spurious_s;
        end
    end

    assign acc_calc_done       = acc_calc_done_r;
    assign calc_start          = calc_start_r;
    assign calc_sel            = calc_sel_r;
    assign pending             = pending_r;
    assign busy                = busy_r;
    assign error_overrun       = err_overrun_r;
    assign error_calc_timeout  = err_timeout_r;
    assign error_spurious_done = err_spurious_r;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed self-checking bench for calc_arbiter with a 20-cycle engine timeout.
module tb_calc_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] start_calc;
    logic [7:0] acc_calc_done;
    logic       calc_start;
    logic [2:0] calc_sel;
    logic       calc_done;
    logic       clear_errors;
    logic [7:0] pending;
    logic       busy;
    logic       error_overrun;
    logic       error_calc_timeout;
    logic       error_spurious_done;

    int checks;
    int errors;

    calc_arbiter #(.N_CH(8), .CH_W(3), .TIMEOUT_CYCLES(20)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_calc          (start_calc),
        .acc_calc_done       (acc_calc_done),
        .calc_start          (calc_start),
        .calc_sel            (calc_sel),
        .calc_done           (calc_done),
        .clear_errors        (clear_errors),
        .pending             (pending),
        .busy                (busy),
        .error_overrun       (error_overrun),
        .error_calc_timeout  (error_calc_timeout),
        .error_spurious_done (error_spurious_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_errs(input string tag, input logic [2:0] exp);
        check(tag, 32'({error_overrun, error_calc_timeout, error_spurious_done}), 32'(exp));
    endtask

    // Called on the calc_start cycle; raises calc_done lat cycles later and checks the ack.
    task automatic serve(input int sel, input int lat);
        check("calc_start", 32'(calc_start), 32'd1);
        check("calc_sel", 32'(calc_sel), 32'(sel));
        repeat (lat) step();
        check("busy_wait", 32'(busy), 32'd1);
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        check("acc_calc_done", 32'(acc_calc_done), 32'(8'h01 << sel));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        start_calc   = 8'h00;
        calc_done    = 1'b0;
        clear_errors = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_calc_start", 32'(calc_start), 32'd0);
        check("rst_acc", 32'(acc_calc_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_sel", 32'(calc_sel), 32'd0);
        check_errs("rst_errs", 3'b000);

        // Single request on channel 2, engine latency 5.
        start_calc = 8'h04;
        step();
        start_calc = 8'h00;
        check("t1_grant_busy", 32'(busy), 32'd1);
        check("t1_no_start_yet", 32'(calc_start), 32'd0);
        step();
        serve(2, 5);
        check_errs("t1_errs", 3'b000);

        // Fairness: all eight channels at once from pointer 0, latency 3, 6-cycle spacing.
        reset = 1'b1;
        step();
        reset = 1'b0;
        start_calc = 8'hFF;
        step();
        start_calc = 8'h00;
        check("t2_pending", 32'(pending), 32'hFE);
        step();
        for (int k = 0; k < 8; k++) begin
            serve(k, 3);
            if (k < 7) begin
                repeat (2) step();
            end
        end
        check("t2_pending_end", 32'(pending), 32'd0);
        check_errs("t2_errs", 3'b000);

        // Pointer wrap: after channel 5, requests 0 and 5 -> channel 0 first.
        start_calc = 8'h20;
        step();
        start_calc = 8'h00;
        step();
        serve(5, 1);
        start_calc = 8'h21;
        step();
        start_calc = 8'h00;
        step();
        check("t3_pending", 32'(pending), 32'h20);
        serve(0, 2);
        repeat (2) step();
        serve(5, 2);

        // Overrun while channel 6 busy, then legal requeue during own wait.
        start_calc = 8'h40;
        step();
        start_calc = 8'h08;
        step();
        check("t4_sel6", 32'(calc_sel), 32'd6);
        start_calc = 8'h08;
        step();
        start_calc = 8'h00;
        check_errs("t4_overrun", 3'b100);
        check("t4_pending", 32'(pending), 32'h08);
        repeat (2) step();
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        check("t4_ack6", 32'(acc_calc_done), 32'h40);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        check_errs("t4_cleared", 3'b000);
        step();
        check("t4_single_grant", 32'(pending), 32'd0);
        check("t4_start3", 32'(calc_start), 32'd1);
        check("t4_sel3", 32'(calc_sel), 32'd3);
        start_calc = 8'h08;
        step();
        start_calc = 8'h00;
        check("t4_requeue", 32'(pending), 32'h08);
        check_errs("t4_no_overrun", 3'b000);
        step();
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        check("t4_ack3", 32'(acc_calc_done), 32'h08);
        repeat (2) step();
        serve(3, 1);
        check_errs("t4_errs_end", 3'b000);

        // Timeout on channel 1 with channel 4 queued behind it.
        start_calc = 8'h02;
        step();
        start_calc = 8'h00;
        step();
        check("t5_start", 32'(calc_start), 32'd1);
        check("t5_sel1", 32'(calc_sel), 32'd1);
        start_calc = 8'h10;
        step();
        start_calc = 8'h00;
        repeat (18) step();
        check_errs("t5_before_to", 3'b000);
        check("t5_busy", 32'(busy), 32'd1);
        step();
        check_errs("t5_timeout", 3'b010);
        check("t5_no_ack", 32'(acc_calc_done), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        check_errs("t5_cleared", 3'b000);
        step();
        serve(4, 2);

        // calc_done on the final timeout cycle counts as completion.
        start_calc = 8'h01;
        step();
        start_calc = 8'h00;
        step();
        serve(0, 19);
        check_errs("t6_no_timeout", 3'b000);

        // Reset during wait with pending 8'h12, then spurious completion.
        start_calc = 8'h40;
        step();
        start_calc = 8'h00;
        step();
        check("t7_sel6", 32'(calc_sel), 32'd6);
        start_calc = 8'h12;
        step();
        start_calc = 8'h00;
        check("t7_pending", 32'(pending), 32'h12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_rst_pending", 32'(pending), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_sel", 32'(calc_sel), 32'd0);
        check("t7_rst_acc", 32'(acc_calc_done), 32'd0);
        step();
        check("t7_no_ack", 32'(acc_calc_done), 32'd0);
        calc_done = 1'b1;
        step();
        calc_done = 1'b0;
        check_errs("t7_spurious", 3'b001);
        check("t7_spur_acc", 32'(acc_calc_done), 32'd0);
        calc_done    = 1'b1;
        clear_errors = 1'b1;
        step();
        calc_done    = 1'b0;
        clear_errors = 1'b0;
        check_errs("t7_set_wins", 3'b001);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        check_errs("t7_clear", 3'b000);
        start_calc = 8'h03;
        step();
        start_calc = 8'h00;
        step();
        serve(0, 1);
        repeat (2) step();
        serve(1, 1);
        check("t7_pending_end", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
